// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Includes the trap-vector target calculation used when a trap redirects the PC.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_VECTOR = 2'd2,
    ST_RET    = 2'd3
  } state_t;

  localparam logic [4:0] INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] BREAKPOINT       = 5'd3;
  localparam logic [4:0] ECALL_M          = 5'd11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // Only interrupts are vectored; exceptions always land on the base address.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_irq,
                                              input logic [4:0]  code);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (is_irq && (mtvec[1:0] == MTVEC_MODE_VECTORED))
      return base + {25'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the interrupt request lines.
// Purely combinational; idx is only meaningful while valid is high.
module irq_prio_enc #(
  parameter int IRQ_LINES = 4
) (
  input  logic [IRQ_LINES-1:0] irq,
  output logic                 valid,
  output logic [3:0]           idx
);

  // Scan from the top down so the lowest set line is the last assignment.
  always_comb begin
    valid = |irq;
    idx   = 4'd0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (irq[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exception/interrupt/mret, writes
// mepc/mcause through the CSR file's direct ports and issues the PC redirect.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int IRQ_LINES      = 4,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 excReq,
  input  logic [4:0]           excCause,
  input  logic [31:0]          excPc,
  input  logic [31:0]          nextPc,
  input  logic                 instrBoundary,
  input  logic [IRQ_LINES-1:0] irq,
  input  logic                 irqEnable,
  input  logic                 mretReq,
  input  logic [31:0]          mtvecDi,
  input  logic [31:0]          mepcDi,
  output logic                 mepcWe,
  output logic                 mcauseWe,
  output logic [31:0]          mepcDo,
  output logic [31:0]          mcauseDo,
  output logic                 stall,
  output logic                 redirect,
  output logic [31:0]          redirectPc
);

  logic       w_irq_valid;
  logic [3:0] w_irq_idx;
  logic       w_irq_take;
  logic [4:0] w_irq_code;

  state_t      r_state;
  logic        r_is_irq;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_mepc_we;
  logic        r_mcause_we;
  logic        r_stall;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;

  irq_prio_enc #(
    .IRQ_LINES(IRQ_LINES)
  ) u_prio (
    .irq  (irq),
    .valid(w_irq_valid),
    .idx  (w_irq_idx)
  );

  assign w_irq_take = irqEnable & instrBoundary & w_irq_valid;
  assign w_irq_code = 5'(IRQ_CAUSE_BASE) + {1'b0, w_irq_idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_is_irq      <= 1'b0;
      r_mepc        <= 32'd0;
      r_mcause      <= 32'd0;
      r_mepc_we     <= 1'b0;
      r_mcause_we   <= 1'b0;
      r_stall       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      // Strobes default low so each is a single-cycle pulse per event.
      r_mepc_we   <= 1'b0;
      r_mcause_we <= 1'b0;
      r_redirect  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (excReq) begin
            r_state     <= ST_SAVE;
            r_is_irq    <= 1'b0;
            r_mepc      <= excPc & 32'hFFFF_FFFC;
            r_mcause    <= {27'd0, excCause};
            r_mepc_we   <= 1'b1;
            r_mcause_we <= 1'b1;
            r_stall     <= 1'b1;
          end else if (w_irq_take) begin
            r_state     <= ST_SAVE;
            r_is_irq    <= 1'b1;
            r_mepc      <= nextPc & 32'hFFFF_FFFC;
            r_mcause    <= {1'b1, 26'd0, w_irq_code};
            r_mepc_we   <= 1'b1;
            r_mcause_we <= 1'b1;
            r_stall     <= 1'b1;
          end else if (mretReq) begin
            r_state       <= ST_RET;
            r_redirect    <= 1'b1;
            r_redirect_pc <= mepcDi;
            r_stall       <= 1'b1;
          end else begin
            r_stall <= 1'b0;
          end
        end
        ST_SAVE: begin
          r_state       <= ST_VECTOR;
          r_redirect    <= 1'b1;
          r_redirect_pc <= trap_target(mtvecDi, r_is_irq, r_mcause[4:0]);
          r_stall       <= 1'b1;
        end
        ST_VECTOR: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
        ST_RET: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign mepcWe     = r_mepc_we;
  assign mcauseWe   = r_mcause_we;
  assign mepcDo     = r_mepc;
  assign mcauseDo   = r_mcause;
  assign stall      = r_stall;
  assign redirect   = r_redirect;
  assign redirectPc = r_redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, randomized
// requests against a spec-level reference model, and multi-cycle corner cases.
module tb_trap_ctrl;

  localparam int KIND_NONE = 0;
  localparam int KIND_TRAP = 1;
  localparam int KIND_MRET = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        excReq;
  logic [4:0]  excCause;
  logic [31:0] excPc;
  logic [31:0] nextPc;
  logic        instrBoundary;
  logic [3:0]  irq;
  logic        irqEnable;
  logic        mretReq;
  logic [31:0] mtvecDi;
  logic [31:0] mepcDi;
  logic        mepcWe;
  logic        mcauseWe;
  logic [31:0] mepcDo;
  logic [31:0] mcauseDo;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;

  int errors = 0;
  int checks = 0;

  trap_ctrl #(
    .IRQ_LINES     (4),
    .IRQ_CAUSE_BASE(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .excReq       (excReq),
    .excCause     (excCause),
    .excPc        (excPc),
    .nextPc       (nextPc),
    .instrBoundary(instrBoundary),
    .irq          (irq),
    .irqEnable    (irqEnable),
    .mretReq      (mretReq),
    .mtvecDi      (mtvecDi),
    .mepcDi       (mepcDi),
    .mepcWe       (mepcWe),
    .mcauseWe     (mcauseWe),
    .mepcDo       (mepcDo),
    .mcauseDo     (mcauseDo),
    .stall        (stall),
    .redirect     (redirect),
    .redirectPc   (redirectPc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic [31:0] next_pc;
    logic [3:0]  irq;
    logic        en;
    logic        bnd;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] mepc_in;
    int          kind;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[12];

  // Control strobes packed as {mepcWe, mcauseWe, stall, redirect}.
  function automatic logic [31:0] ctrl();
    return {28'd0, mepcWe, mcauseWe, stall, redirect};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    excReq = 1'b0; excCause = 5'd0; excPc = 32'd0; nextPc = 32'd0;
    instrBoundary = 1'b0; irq = 4'd0; irqEnable = 1'b0; mretReq = 1'b0;
    mtvecDi = 32'd0; mepcDi = 32'd0;
  endtask

  function automatic vec_t mk(input logic exc, input logic [4:0] cause, input logic [31:0] exc_pc,
                              input logic [31:0] next_pc, input logic [3:0] irq_v, input logic en,
                              input logic bnd, input logic mret, input logic [31:0] mtvec,
                              input logic [31:0] mepc_in, input int kind, input logic [31:0] e_mepc,
                              input logic [31:0] e_mcause, input logic [31:0] e_pc);
    vec_t v;
    v.exc = exc; v.cause = cause; v.exc_pc = exc_pc; v.next_pc = next_pc; v.irq = irq_v;
    v.en = en; v.bnd = bnd; v.mret = mret; v.mtvec = mtvec; v.mepc_in = mepc_in;
    v.kind = kind; v.e_mepc = e_mepc; v.e_mcause = e_mcause; v.e_pc = e_pc;
    return v;
  endfunction

  // Reference model straight from the arbitration and vectoring rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   lowest;
    int   code;
    r = v;
    r.kind = KIND_NONE; r.e_mepc = 0; r.e_mcause = 0; r.e_pc = 0;
    lowest = -1;
    for (int i = 3; i >= 0; i--) if (v.irq[i]) lowest = i;
    if (v.exc) begin
      r.kind     = KIND_TRAP;
      r.e_mepc   = v.exc_pc - (v.exc_pc % 4);
      r.e_mcause = 32'(v.cause);
      r.e_pc     = v.mtvec - (v.mtvec % 4);
    end else if (v.en && v.bnd && lowest >= 0) begin
      code       = (16 + lowest) % 32;
      r.kind     = KIND_TRAP;
      r.e_mepc   = v.next_pc - (v.next_pc % 4);
      r.e_mcause = 32'h8000_0000 + 32'(code);
      r.e_pc     = v.mtvec - (v.mtvec % 4);
      if (v.mtvec % 4 == 1) r.e_pc = r.e_pc + 32'(4 * code);
    end else if (v.mret) begin
      r.kind = KIND_MRET;
      r.e_pc = v.mepc_in;
    end
    return r;
  endfunction

  // Starts right after a negedge with the DUT idle; ends three cycles later.
  task automatic run_vec(input vec_t v, input string tag);
    excReq = v.exc; excCause = v.cause; excPc = v.exc_pc; nextPc = v.next_pc;
    irq = v.irq; irqEnable = v.en; instrBoundary = v.bnd; mretReq = v.mret;
    mtvecDi = v.mtvec; mepcDi = v.mepc_in;
    @(negedge clk);
    if (v.kind == KIND_TRAP) begin
      check({tag, " save ctrl"}, ctrl(), 32'hE);
      check({tag, " mepcDo"}, mepcDo, v.e_mepc);
      check({tag, " mcauseDo"}, mcauseDo, v.e_mcause);
    end else if (v.kind == KIND_MRET) begin
      check({tag, " ret ctrl"}, ctrl(), 32'h3);
      check({tag, " ret pc"}, redirectPc, v.e_pc);
    end else begin
      check({tag, " idle ctrl"}, ctrl(), 32'h0);
    end
    @(negedge clk);
    if (v.kind == KIND_TRAP) begin
      check({tag, " vector ctrl"}, ctrl(), 32'h3);
      check({tag, " vector pc"}, redirectPc, v.e_pc);
    end else begin
      check({tag, " cycle2 ctrl"}, ctrl(), 32'h0);
    end
    excReq = 1'b0; mretReq = 1'b0; irq = 4'd0;
    @(negedge clk);
    check({tag, " end ctrl"}, ctrl(), 32'h0);
    $display("%s: exc=%b irq=%b en=%b bnd=%b mret=%b kind=%0d mepc=%h mcause=%h pc=%h",
             tag, v.exc, v.irq, v.en, v.bnd, v.mret, v.kind, v.e_mepc, v.e_mcause, v.e_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    clear_inputs();
    reset = 1'b0;

    tbl[0]  = mk(1, 5'd2, 32'h104, 32'h0, 4'b0000, 0, 0, 0, 32'h1000, 32'h0,
                 KIND_TRAP, 32'h104, 32'h2, 32'h1000);
    tbl[1]  = mk(0, 5'd0, 32'h0, 32'h200, 4'b0110, 1, 1, 0, 32'h2001, 32'h0,
                 KIND_TRAP, 32'h200, 32'h8000_0011, 32'h2044);
    tbl[2]  = mk(0, 5'd0, 32'h0, 32'h0, 4'b0000, 0, 0, 1, 32'h0, 32'h300,
                 KIND_MRET, 32'h0, 32'h0, 32'h300);
    tbl[3]  = mk(0, 5'd0, 32'h0, 32'h200, 4'b1111, 0, 1, 0, 32'h2001, 32'h0,
                 KIND_NONE, 32'h0, 32'h0, 32'h0);
    tbl[4]  = mk(0, 5'd0, 32'h0, 32'h200, 4'b1111, 1, 0, 0, 32'h2001, 32'h0,
                 KIND_NONE, 32'h0, 32'h0, 32'h0);
    tbl[5]  = mk(1, 5'd3, 32'h10, 32'h14, 4'b0001, 1, 1, 1, 32'h2001, 32'h77,
                 KIND_TRAP, 32'h10, 32'h3, 32'h2000);
    tbl[6]  = mk(1, 5'd0, 32'h10F, 32'h0, 4'b0000, 0, 0, 0, 32'h1003, 32'h0,
                 KIND_TRAP, 32'h10C, 32'h0, 32'h1000);
    tbl[7]  = mk(0, 5'd0, 32'h0, 32'h207, 4'b1000, 1, 1, 0, 32'h2001, 32'h0,
                 KIND_TRAP, 32'h204, 32'h8000_0013, 32'h204C);
    tbl[8]  = mk(0, 5'd0, 32'h0, 32'h8, 4'b0001, 1, 1, 0, 32'hFFFF_FFFD, 32'h0,
                 KIND_TRAP, 32'h8, 32'h8000_0010, 32'h3C);
    tbl[9]  = mk(0, 5'd0, 32'h0, 32'h40, 4'b0100, 1, 1, 0, 32'h3000, 32'h0,
                 KIND_TRAP, 32'h40, 32'h8000_0012, 32'h3000);
    tbl[10] = mk(0, 5'd0, 32'h0, 32'h0, 4'b0011, 0, 1, 1, 32'h1000, 32'hABCD_0000,
                 KIND_MRET, 32'h0, 32'h0, 32'hABCD_0000);
    tbl[11] = mk(0, 5'd0, 32'h0, 32'h500, 4'b0010, 1, 1, 1, 32'h1000, 32'h900,
                 KIND_TRAP, 32'h500, 32'h8000_0011, 32'h1000);

    repeat (2) @(negedge clk);
    check("reset ctrl", ctrl(), 32'h0);
    check("reset mepcDo", mepcDo, 32'h0);
    check("reset mcauseDo", mcauseDo, 32'h0);
    check("reset redirectPc", redirectPc, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset ctrl", ctrl(), 32'h0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("dir%0d", i));

    // Exception beats a held interrupt; the interrupt is taken on return to IDLE.
    clear_inputs();
    mtvecDi = 32'h2001; nextPc = 32'h600;
    excReq = 1'b1; excCause = ECALL_M_CODE(); excPc = 32'h400;
    irq = 4'b0001; irqEnable = 1'b1; instrBoundary = 1'b1; mretReq = 1'b1;
    @(negedge clk);
    check("arb exc save ctrl", ctrl(), 32'hE);
    check("arb exc mcause", mcauseDo, 32'd11);
    check("arb exc mepc", mepcDo, 32'h400);
    @(negedge clk);
    check("arb exc vector ctrl", ctrl(), 32'h3);
    check("arb exc pc", redirectPc, 32'h2000);
    excReq = 1'b0; mretReq = 1'b0;
    @(negedge clk);
    check("arb idle ctrl", ctrl(), 32'h0);
    @(negedge clk);
    check("arb irq save ctrl", ctrl(), 32'hE);
    check("arb irq mcause", mcauseDo, 32'h8000_0010);
    check("arb irq mepc", mepcDo, 32'h600);
    irq = 4'b0000;
    @(negedge clk);
    check("arb irq vector ctrl", ctrl(), 32'h3);
    check("arb irq pc", redirectPc, 32'h2040);
    @(negedge clk);
    check("arb end ctrl", ctrl(), 32'h0);
    $display("arb: exception then held interrupt sequence done");

    // Reset asserted during SAVE clears everything at once and nothing follows.
    clear_inputs();
    mtvecDi = 32'h1000; excReq = 1'b1; excCause = 5'd2; excPc = 32'h88;
    @(posedge clk);
    #2;
    check("midrst save ctrl", ctrl(), 32'hE);
    reset = 1'b0;
    #1;
    check("midrst ctrl", ctrl(), 32'h0);
    check("midrst mepcDo", mepcDo, 32'h0);
    check("midrst mcauseDo", mcauseDo, 32'h0);
    check("midrst redirectPc", redirectPc, 32'h0);
    excReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrst after%0d ctrl", i), ctrl(), 32'h0);
    end
    $display("midrst: reset during SAVE done");

    for (int n = 0; n < 100; n++) begin
      v.exc     = ($urandom_range(0, 2) == 0);
      v.cause   = 5'($urandom);
      v.exc_pc  = $urandom;
      v.next_pc = $urandom;
      v.irq     = 4'($urandom);
      v.en      = 1'($urandom);
      v.bnd     = 1'($urandom);
      v.mret    = 1'($urandom);
      v.mtvec   = $urandom;
      v.mepc_in = $urandom;
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [4:0] ECALL_M_CODE();
    return trap_pkg::ECALL_M;
  endfunction

endmodule
